// File: rtl/addsub_pkg.sv
// Shared types and sizing for the digit-serial 12-bit adder/subtractor.
// The FSM state enum and digit-index type live here so top and bench agree.
package addsub_pkg;

  localparam int WIDTH = 12;
  localparam int DIGIT = 3;
  localparam int NDIG  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] dig_t;

endpackage

// File: rtl/addsub_12b_serial_if.sv
// Operand and result handshakes of the serial adder/subtractor.
// The master drives operands and result acceptance; the slave is the datapath.
interface addsub_12b_serial_if #(
  parameter int WIDTH = addsub_pkg::WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );

endinterface

// File: rtl/addsub_12b_serial_cla.sv
// 3-bit carry-lookahead slice shared across all digit cycles of the serial adder.
module CLA_3b (
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       Cin,
  output logic [2:0] S,
  output logic       Co
);

  logic [2:0] p;
  logic [2:0] g;
  logic       c1;
  logic       c2;

  assign p  = A ^ B;
  assign g  = A & B;
  assign c1 = g[0] | (p[0] & Cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign Co = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
  assign S  = p ^ {c2, c1, Cin};

endmodule

// File: rtl/addsub_12b_serial.sv
// Digit-serial adder/subtractor: one CLA_3b slice walks the operands LSD first
// over NDIG cycles, then holds the result until the consumer accepts it.
module addsub_12b_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = addsub_pkg::WIDTH,
  parameter int DIGIT = addsub_pkg::DIGIT,
  parameter int NDIG  = addsub_pkg::NDIG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_12b_serial_if.slave   bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] beff_q, beff_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  dig_t             dig_q, dig_d;

  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co;

  assign slice_a = a_q[int'(dig_q)*DIGIT +: DIGIT];
  assign slice_b = beff_q[int'(dig_q)*DIGIT +: DIGIT];

  CLA_3b u_slice (
    .A   (slice_a),
    .B   (slice_b),
    .Cin (carry_q),
    .S   (slice_s),
    .Co  (slice_co)
  );

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    a_d     = a_q;
    beff_d  = beff_q;
    s_d     = s_q;
    carry_d = carry_q;
    dig_d   = dig_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1: invert B now, inject the +1 as the first carry.
          a_d     = bus.a;
          beff_d  = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          dig_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[int'(dig_q)*DIGIT +: DIGIT] = slice_s;
        carry_d = slice_co;
        dig_d   = dig_q + dig_t'(1);
        if (dig_q == dig_t'(NDIG-1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset too, so s/co/ovf read 0 the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      beff_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      dig_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      beff_q  <= beff_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.co        = carry_q;
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign bus.ovf       = bus.out_valid
                       & (a_q[WIDTH-1] == beff_q[WIDTH-1])
                       & (s_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_addsub_12b_serial.sv
// Directed bench for addsub_12b_serial: hand-computed vectors, an arithmetic
// reference model checked every DONE cycle, backpressure and mid-run reset.
module tb_addsub_12b_serial;
  import addsub_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  addsub_12b_serial_if bus ();

  addsub_12b_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic        sub;
    logic [11:0] s;
    logic        co;
    logic        ovf;
    logic [3:0]  hold;
  } vec_t;

  logic [11:0] exp_s;
  logic        exp_co;
  logic        exp_ovf;
  logic        exp_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Plain integer arithmetic, unsigned for s/co and signed for overflow.
  function automatic logic [13:0] model(input logic [11:0] a, input logic [11:0] b, input logic sub);
    int ua, ub, sa, sb, r, sr;
    logic c, o;
    logic [11:0] s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r > 4095);
      sr = sa + sb;
    end
    s = r[11:0];
    o = (sr > 2047) || (sr < -2048);
    return {s, c, o};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("exclusive_ready_valid", {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
      if (bus.out_valid && exp_valid) begin
        check("model_s",   {20'd0, bus.s},    {20'd0, exp_s});
        check("model_co",  {31'd0, bus.co},   {31'd0, exp_co});
        check("model_ovf", {31'd0, bus.ovf},  {31'd0, exp_ovf});
      end
    end
  end

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic sub);
    logic [13:0] m;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
    m         = model(a, b, sub);
    exp_s     = m[13:2];
    exp_co    = m[1];
    exp_ovf   = m[0];
    exp_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    logic [11:0] s0;
    logic        co0;
    logic        ovf0;
    send(v.a, v.b, v.sub);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", lat, 32'd4);
    check("vec_s",   {20'd0, bus.s},   {20'd0, v.s});
    check("vec_co",  {31'd0, bus.co},  {31'd0, v.co});
    check("vec_ovf", {31'd0, bus.ovf}, {31'd0, v.ovf});
    s0   = bus.s;
    co0  = bus.co;
    ovf0 = bus.ovf;
    for (int i = 0; i < int'(v.hold); i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a        = 12'($urandom);
      bus.b        = 12'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_in_ready",  {31'd0, bus.in_ready},  32'd0);
      check("hold_s",   {20'd0, bus.s},   {20'd0, s0});
      check("hold_co",  {31'd0, bus.co},  {31'd0, co0});
      check("hold_ovf", {31'd0, bus.ovf}, {31'd0, ovf0});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk);
    check("retire_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("retire_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  vec_t vecs [7];
  logic [13:0] pin;

  initial begin
    checks = 0;
    errors = 0;
    exp_valid = 1'b0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0] = {12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1, 4'd0};
    vecs[1] = {12'h000, 12'h001, 1'b1, 12'hFFF, 1'b0, 1'b0, 4'd0};
    vecs[2] = {12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0, 4'd0};
    vecs[3] = {12'h800, 12'h001, 1'b1, 12'h7FF, 1'b1, 1'b1, 4'd0};
    vecs[4] = {12'h5A5, 12'h3C3, 1'b1, 12'h1E2, 1'b1, 1'b0, 4'd3};
    vecs[5] = {12'h800, 12'h800, 1'b0, 12'h000, 1'b1, 1'b1, 4'd0};
    vecs[6] = {12'hABC, 12'h123, 1'b0, 12'hBDF, 1'b0, 1'b0, 4'd1};

    pin = model(12'h7FF, 12'h001, 1'b0);
    check("model_pin_add_ovf", {18'd0, pin}, {18'd0, 12'h800, 1'b0, 1'b1});
    pin = model(12'h000, 12'h001, 1'b1);
    check("model_pin_borrow",  {18'd0, pin}, {18'd0, 12'hFFF, 1'b0, 1'b0});
    pin = model(12'h800, 12'h001, 1'b1);
    check("model_pin_sub_ovf", {18'd0, pin}, {18'd0, 12'h7FF, 1'b1, 1'b1});

    #1;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_s",   {20'd0, bus.s},   32'd0);
    check("rst_co",  {31'd0, bus.co},  32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort 0x123 + 0x456 after its second digit edge.
    send(12'h123, 12'h456, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_s",   {20'd0, bus.s},   32'd0);
    check("abort_co",  {31'd0, bus.co},  32'd0);
    check("abort_ovf", {31'd0, bus.ovf}, 32'd0);
    exp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec({12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0, 4'd0});

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_12b_serial.md
# addsub_12b_serial

Digit-serial 12-bit adder/subtractor that time-multiplexes a single 3-bit carry-lookahead slice over four cycles, least-significant digit first. It is the subtract-capable, sequential counterpart to the parallel 12-bit CLA datapath. It is used where area matters more than latency. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake with backpressure.

## Interface
Parameters:
- `WIDTH`, 12: operand width; must equal `DIGIT * NDIG`.
- `DIGIT`, 3: slice width; fixed by the CLA slice.
- `NDIG`, 4: number of digit cycles, `WIDTH/DIGIT`.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  12  operand A.
- `b`  in  12  operand B.
- `sub`  in  1  0 = A+B, 1 = A−B.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `s`  out  12  sum or difference.
- `co`  out  1  carry out of bit 11; in subtract mode 1 = no borrow (A ≥ B unsigned).
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- FSM states: `IDLE`, `RUN`, `DONE`.
- **IDLE:** `in_ready=1`. When `in_valid && in_ready` at an edge:
  - latch `a`, `b ^ {12{sub}}` and `sub`;
  - set the carry register to `sub` and the digit counter to 0;
  - go to RUN.
- **RUN:** each edge, the slice adds digit `k` (bits `3k+2:3k`) of A and effective B with the carry register.
  - Write the 3-bit result into `s[3k+2:3k]`; store the slice `Co` in the carry register; increment `k`.
  - After digit 3 (k wraps 3→0), go to DONE.
  - `in_valid` is ignored in RUN.
- **DONE:** `out_valid=1`.
  - `co` = final carry register.
  - `ovf = (a[11] == beff[11]) && (s[11] != a[11])`, evaluated on the latched operands.
  - On `out_valid && out_ready`, go to IDLE.
- Outputs `s`, `co` and `ovf` are held stable for the whole of DONE.
- Arithmetic is modulo 2^12; there is no saturation.

## Timing
- Reset (async, `rst_n=0`):
  - state IDLE; `in_ready=1`; `out_valid=0`; `s=0`; `co=0`; `ovf=0`;
  - carry register and digit counter 0.
- Reset mid-RUN or mid-DONE aborts the operation. The result is discarded; there is no partial output.
- Acceptance edge E0, then digit edges E1–E4. `out_valid` is high in the cycle following E4, giving a latency of 4 cycles from acceptance to `out_valid`.
- Result handshake at edge Ed: `in_ready` rises in the cycle after Ed. No new operands are accepted in the same cycle as result retirement. Minimum initiation interval is 6 cycles.
- `out_ready` held low: remain in DONE indefinitely with outputs stable and `in_ready=0`.
- `out_ready` is don't-care outside DONE.
- `in_ready` and `out_valid` are never both 1.

## Structure
- Shared package `addsub_pkg`:
  - `state_t` enum {IDLE, RUN, DONE};
  - localparams `WIDTH`, `DIGIT`, `NDIG`;
  - digit-index type `logic [1:0]`.
- One sub-module: the existing `CLA_3b` instantiated once as the digit slice (`A`, `B`, `Cin` → `S`, `Co`).
  - Its inputs are muxed from the latched operands by digit index; its outputs are captured into `s` and the carry register.
- Everything else lives in the top module: FSM, operand registers, carry register, counter, output registers.

## Test plan
- `a=0x7FF`, `b=0x001`, `sub=0` → `s=0x800`, `co=0`, `ovf=1`; `out_valid` high exactly 4 cycles after acceptance.
- `a=0x000`, `b=0x001`, `sub=1` → `s=0xFFF`, `co=0` (borrow), `ovf=0`.
- `a=0xFFF`, `b=0x001`, `sub=0` → `s=0x000`, `co=1`, `ovf=0`. This carry ripples through all four digit cycles.
- `a=0x800`, `b=0x001`, `sub=1` → `s=0x7FF`, `co=1`, `ovf=1`.
- Backpressure:
  - Hold `out_ready=0` for 3 cycles in DONE while toggling `in_valid` and `a`/`b`.
  - Required: `s`, `co`, `ovf` and `out_valid` stay stable and `in_ready=0`.
  - On `out_ready=1`, IDLE follows and `in_ready=1` in the next cycle.
- Reset mid-operation:
  - Assert `rst_n=0` after E2 of `0x123 + 0x456`.
  - Required: all outputs read their reset values immediately, without waiting for a clock edge.
  - After release, a fresh `0x123 + 0x456` yields `s=0x579`, `co=0`, `ovf=0`.
